// File: rtl/agc_controller.sv
// Peak-tracking AGC loop: windowed envelope peak, deadband decision, settle hold.
// Optional fast-attack path on large samples: define AGC_FAST_ATTACK_EN.
module agc_controller #(
  parameter int WINDOW_LOG2  = 6,
  parameter int HOLD_SAMPLES = 16,
  parameter int GAIN_MAX     = 15,
  parameter int GAIN_INIT    = 8,
  parameter int HYST         = 4,
  parameter int CLIP         = 120
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] env_in,
  input  logic [7:0] target,
  output logic [3:0] gain,
  output logic       gain_stb,
  output logic       locked,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [3:0]             gain_n;
  logic                   stb_n, locked_n;
  logic [6:0]             peak, peak_n, mag;
  logic [WINDOW_LOG2-1:0] win_cnt, win_n;
  logic [HW-1:0]          hold_cnt, hold_n;
  logic [8:0]             peak9, tgt9;
  logic                   go_down, go_up, fast;

  assign mag   = env_in[7] ? 7'd0 : env_in[6:0];
  assign peak9 = {2'b00, peak};
  assign tgt9  = {1'b0, target};

  // 9-bit compares so target+HYST never wraps
  assign go_down = (peak9 > tgt9 + 9'(HYST)) && (gain != 4'd0);
  assign go_up   = (peak9 + 9'(HYST) < tgt9)
                && (gain < 4'(GAIN_MAX));

`ifdef AGC_FAST_ATTACK_EN
  assign fast = sample_valid && (gain != 4'd0)
             && ({2'b00, mag} >= 9'(CLIP));
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    gain_n   = gain;
    stb_n    = 1'b0;
    locked_n = locked;
    peak_n   = peak;
    win_n    = win_cnt;
    hold_n   = hold_cnt;
    if (!enable) begin
      state_n = IDLE;
      peak_n  = '0;
      win_n   = '0;
      hold_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ACCUM;
          peak_n  = '0;
          win_n   = '0;
          hold_n  = '0;
        end
        ACCUM: begin
          if (fast) begin
            gain_n   = gain - 4'd1;
            stb_n    = 1'b1;
            locked_n = 1'b0;
            peak_n   = '0;
            win_n    = '0;
            hold_n   = '0;
            state_n  = HOLD;
          end else if (sample_valid) begin
            if (mag > peak) peak_n = mag;
            win_n = win_cnt + 1'b1;
            if (&win_cnt) state_n = DECIDE;
          end
        end
        DECIDE: begin
          hold_n = '0;
          if (go_down || go_up) begin
            gain_n   = go_down ? gain - 4'd1 : gain + 4'd1;
            stb_n    = 1'b1;
            locked_n = 1'b0;
            state_n  = HOLD;
          end else begin
            locked_n = 1'b1;
            peak_n   = '0;
            win_n    = '0;
            state_n  = ACCUM;
          end
        end
        HOLD: begin
          if (sample_valid) begin
            if (hold_cnt == HW'(HOLD_SAMPLES - 1)) begin
              hold_n  = '0;
              peak_n  = '0;
              win_n   = '0;
              state_n = ACCUM;
            end else begin
              hold_n = hold_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      gain     <= 4'(GAIN_INIT);
      gain_stb <= 1'b0;
      locked   <= 1'b0;
      busy     <= 1'b0;
      peak     <= '0;
      win_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gain     <= gain_n;
      gain_stb <= stb_n;
      locked   <= locked_n;
      busy     <= (state_n != IDLE);
      peak     <= peak_n;
      win_cnt  <= win_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_agc_controller.sv
// Directed bench for agc_controller: window decisions, hold, saturation,
// enable drop, reset mid-hold, fast attack (when AGC_FAST_ATTACK_EN is set).
module tb_agc_controller;

  logic       clk = 1'b0;
  logic       RST;
  logic       enable;
  logic       sample_valid;
  logic [7:0] env_in;
  logic [7:0] target;
  logic [3:0] gain;
  logic       gain_stb;
  logic       locked;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  agc_controller dut (
    .clk          (clk),
    .RST          (RST),
    .enable       (enable),
    .sample_valid (sample_valid),
    .env_in       (env_in),
    .target       (target),
    .gain         (gain),
    .gain_stb     (gain_stb),
    .locked       (locked),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    enable = 1'b1;
    sample_valid = 1'b1;
    env_in = 8'd100;
    target = 8'd10;
    step;
    step;
    RST = 1'b0;
    enable = 1'b0;
    step;
  endtask

  // n = cycles until the first gain_stb, -1 if none within limit
  task automatic wait_stb(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step;
      if (gain_stb) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    enable = 1'b1;
    sample_valid = 1'b1;
    env_in = 8'd100;
    target = 8'd10;
    step;
    step;
    n_tests++; if (gain !== 4'd8) begin n_fail++; $display("FAIL reset_gain: got %0d expected 8", gain); end
    n_tests++; if (gain_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %0b expected 0", gain_stb); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    RST = 1'b0;
    enable = 1'b0;
    step;
  endtask

  task automatic test_gain_up;
    int n;
    do_reset;
    env_in = 8'd30;
    target = 8'd64;
    sample_valid = 1'b1;
    enable = 1'b1;
    step;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy: got %0b expected 1", busy); end
    wait_stb(200, n);
    n_tests++; if (n !== 65) begin n_fail++; $display("FAIL up_latency: got %0d expected 65", n); end
    n_tests++; if (gain !== 4'd9) begin n_fail++; $display("FAIL up_gain: got %0d expected 9", gain); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL up_locked: got %0b expected 0", locked); end
    step;
    n_tests++; if (gain_stb !== 1'b0) begin n_fail++; $display("FAIL up_stb_pulse: got %0b expected 0", gain_stb); end
    // 16 hold samples + 64 window samples + decide, counted from the cycle after the pulse
    wait_stb(200, n);
    n_tests++; if (n !== 80) begin n_fail++; $display("FAIL up_hold_len: got %0d expected 80", n); end
    n_tests++; if (gain !== 4'd10) begin n_fail++; $display("FAIL up_gain2: got %0d expected 10", gain); end
  endtask

  task automatic test_lock;
    int pulses;
    do_reset;
    env_in = 8'd64;
    target = 8'd64;
    sample_valid = 1'b1;
    enable = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 65; i++) begin
      step;
      if (gain_stb) pulses++;
    end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b expected 0", locked); end
    step;
    if (gain_stb) pulses++;
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %0b expected 1", locked); end
    n_tests++; if (gain !== 4'd8) begin n_fail++; $display("FAIL lock_gain: got %0d expected 8", gain); end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL lock_stb: got %0d pulses expected 0", pulses); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_busy: got %0b expected 1", busy); end
    // ACCUM restarts with no hold: next window needs 64 samples + decide
    env_in = 8'd30;
    wait_stb(200, pulses);
    n_tests++; if (pulses !== 65) begin n_fail++; $display("FAIL lock_restart: got %0d expected 65", pulses); end
  endtask

  task automatic test_decide_table;
    logic [7:0] ev [11] = '{8'd30, 8'd59, 8'd60, 8'd68, 8'd69, 8'd0,
                            8'd119, 8'd0, 8'hF0, 8'h80, 8'd119};
    logic [7:0] tv [11] = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd0,
                            8'd0, 8'd127, 8'd3, 8'd5, 8'd115};
    logic [3:0] gv [11] = '{4'd9, 4'd9, 4'd8, 4'd8, 4'd7, 4'd8,
                            4'd7, 4'd9, 4'd8, 4'd9, 4'd8};
    for (int k = 0; k < 11; k++) begin
      do_reset;
      env_in = ev[k];
      target = tv[k];
      sample_valid = 1'b1;
      enable = 1'b1;
      repeat (66) step;
      n_tests++; if (gain !== gv[k]) begin n_fail++; $display("FAIL decide_gain[%0d]: got %0d expected %0d", k, gain, gv[k]); end
      n_tests++; if (locked !== (gv[k] == 4'd8)) begin n_fail++; $display("FAIL decide_locked[%0d]: got %0b expected %0b", k, locked, gv[k] == 4'd8); end
      n_tests++; if (gain_stb !== (gv[k] != 4'd8)) begin n_fail++; $display("FAIL decide_stb[%0d]: got %0b expected %0b", k, gain_stb, gv[k] != 4'd8); end
    end
  endtask

  task automatic test_saturate;
    int pulses;
    do_reset;
    env_in = 8'h9C;
    target = 8'd64;
    sample_valid = 1'b1;
    enable = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 1000; i++) begin
      step;
      if (gain_stb) pulses++;
    end
    n_tests++; if (pulses !== 7) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 7", pulses); end
    n_tests++; if (gain !== 4'd15) begin n_fail++; $display("FAIL sat_gain: got %0d expected 15", gain); end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_fast_attack;
    int n;
    do_reset;
    target = 8'd64;
    sample_valid = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      env_in = (i == 4) ? 8'd125 : 8'd64;
      step;
    end
    env_in = 8'd64;
`ifdef AGC_FAST_ATTACK_EN
    n_tests++; if (gain !== 4'd7) begin n_fail++; $display("FAIL fa_gain: got %0d expected 7", gain); end
    n_tests++; if (gain_stb !== 1'b1) begin n_fail++; $display("FAIL fa_stb: got %0b expected 1", gain_stb); end
    // hold 16 + window 64 + decide = 81 cycles, unchanged gain so lock
    repeat (81) step;
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL fa_locked: got %0b expected 1", locked); end
    n_tests++; if (gain !== 4'd7) begin n_fail++; $display("FAIL fa_gain_hold: got %0d expected 7", gain); end
`else
    n_tests++; if (gain !== 4'd8) begin n_fail++; $display("FAIL nofa_gain: got %0d expected 8", gain); end
    wait_stb(200, n);
    n_tests++; if (n !== 62) begin n_fail++; $display("FAIL nofa_latency: got %0d expected 62", n); end
    n_tests++; if (gain !== 4'd7) begin n_fail++; $display("FAIL nofa_gain_dec: got %0d expected 7", gain); end
`endif
  endtask

  task automatic test_enable_drop;
    int n;
    do_reset;
    env_in = 8'd30;
    target = 8'd64;
    sample_valid = 1'b1;
    enable = 1'b1;
    repeat (41) step;
    enable = 1'b0;
    step;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %0b expected 0", busy); end
    n_tests++; if (gain !== 4'd8) begin n_fail++; $display("FAIL drop_gain: got %0d expected 8", gain); end
    step;
    enable = 1'b1;
    wait_stb(200, n);
    n_tests++; if (n !== 66) begin n_fail++; $display("FAIL drop_reentry: got %0d expected 66", n); end
    n_tests++; if (gain !== 4'd9) begin n_fail++; $display("FAIL drop_gain2: got %0d expected 9", gain); end
  endtask

  task automatic test_reset_in_hold;
    int n;
    do_reset;
    env_in = 8'd30;
    target = 8'd64;
    sample_valid = 1'b1;
    enable = 1'b1;
    wait_stb(200, n);
    repeat (5) step;
    n_tests++; if (gain !== 4'd9) begin n_fail++; $display("FAIL rh_pre_gain: got %0d expected 9", gain); end
    RST = 1'b1;
    step;
    n_tests++; if (gain !== 4'd8) begin n_fail++; $display("FAIL rh_gain: got %0d expected 8", gain); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rh_busy: got %0b expected 0", busy); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rh_locked: got %0b expected 0", locked); end
    RST = 1'b0;
    wait_stb(200, n);
    n_tests++; if (n !== 66) begin n_fail++; $display("FAIL rh_fresh_window: got %0d expected 66", n); end
  endtask

  initial begin
    RST = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    env_in = 8'd0;
    target = 8'd0;
    #1;
    test_reset;
    test_gain_up;
    test_lock;
    test_decide_table;
    test_saturate;
    test_fast_attack;
    test_enable_drop;
    test_reset_in_hold;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_controller.md
AGC_CONTROLLER -- requirements
Module: agc_controller

Interface
REQ-001 Parameter WINDOW_LOG2, default 6: an envelope measurement window is 2^WINDOW_LOG2 valid samples.
REQ-002 Parameter HOLD_SAMPLES, default 16: valid samples ignored after each gain change so the envelope filter can settle.
REQ-003 Parameter GAIN_MAX, default 15: upper gain code limit.
REQ-004 Parameter GAIN_INIT, default 8: gain code at reset.
REQ-005 Parameter HYST, default 4: deadband half-width around target.
REQ-006 Parameter CLIP, default 120: fast-attack threshold, used only with REQ-027.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 RST  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  loop run control.
REQ-010 sample_valid  input  1  one-cycle strobe: env_in holds a new envelope sample.
REQ-011 env_in  input  8 signed  envelope detector output.
REQ-012 target  input  8 unsigned  desired peak envelope, 0..127.
REQ-013 gain  output  4  registered gain code for the IF gain stage.
REQ-014 gain_stb  output  1  one-cycle pulse, coincident with every gain change.
REQ-015 locked  output  1  high while the last decision left gain unchanged.
REQ-016 busy  output  1  high in ACCUM, DECIDE and HOLD.

Function
REQ-017 States: IDLE, ACCUM, DECIDE, HOLD, with one state register.
REQ-018 IDLE: when enable=1, the FSM moves to ACCUM on the next edge, with peak and sample counter cleared.
REQ-019 Sample magnitude = env_in when env_in >= 0, otherwise 0, giving a 7-bit unsigned value.
REQ-020 ACCUM, on each sample_valid: peak <= max(peak, magnitude) and the counter increments. When the counter reaches 2^WINDOW_LOG2-1 with sample_valid, the counter wraps to 0 and the FSM moves to DECIDE.
REQ-021 DECIDE lasts exactly 1 cycle, with this priority:
- If peak > target+HYST and gain > 0: gain-1.
- Else if peak + HYST < target and gain < GAIN_MAX: gain+1.
- Else: gain unchanged.
- Comparisons use 9-bit unsigned arithmetic, so there is no wrap.
REQ-022 On a gain change in DECIDE, gain and gain_stb update on the DECIDE-exit edge, locked <= 0, and the FSM moves to HOLD.
REQ-023 With no change in DECIDE, gain_stb stays 0, locked <= 1, and the FSM moves directly to ACCUM, skipping HOLD.
REQ-024 A gain already at 0 or GAIN_MAX that is requested to move further counts as "no change" (locked <= 1).
REQ-025 HOLD counts HOLD_SAMPLES sample_valid strobes, then moves to ACCUM with peak and counter cleared. sample_valid has no effect on peak in HOLD and DECIDE.
REQ-026 enable=0 in any state: the FSM moves to IDLE on the next edge. gain and locked are retained, gain_stb is 0, and any partial window is discarded.

Reset
REQ-030 While RST=1 at a clk edge, the block is forced to the following, regardless of other inputs:
- state=IDLE
- gain=GAIN_INIT
- gain_stb=0
- locked=0
- busy=0
- peak=0
- both counters=0
REQ-031 Reset asserted mid-window or mid-HOLD abandons the operation. The first window after release starts fresh.
REQ-032 All outputs are registered, and none depend combinationally on inputs.

Configuration
REQ-027 Macro AGC_FAST_ATTACK_EN defined: in ACCUM, a sample_valid with magnitude >= CLIP while gain > 0 causes all of the following on that edge, bypassing DECIDE:
- gain-1
- gain_stb pulse
- locked <= 0
- peak and counter cleared
- FSM moves to HOLD
REQ-028 Macro AGC_FAST_ATTACK_EN undefined: no CLIP logic is synthesised. Large samples are handled only by REQ-021 at window end.
REQ-029 If fast attack and window completion coincide on the same sample, the fast-attack action applies and the window completion is dropped.

Verification
REQ-033 Reset then enable with env_in=30, target=64, continuous sample_valid: after 64 samples, gain 8->9 with gain_stb, then HOLD lasts 16 samples.
REQ-034 env_in=64, target=64: after the window, gain stays 8, gain_stb stays 0, locked=1, and ACCUM restarts immediately.
REQ-035 env_in=-100 constant, target=64: magnitude is 0, gain ramps to 15 and saturates, then locked=1.
REQ-036 With AGC_FAST_ATTACK_EN, env_in=125 on sample 3: gain 8->7 on that edge and HOLD is entered. Without the macro, the decrement occurs only after sample 64.
REQ-037 Drop enable mid-ACCUM at sample 40 and re-assert: the FSM goes to IDLE, gain is retained, and the next decision occurs 64 samples after re-entry.
REQ-038 Assert RST during HOLD: all outputs return to their reset values next edge, and gain=8.
